// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU round-robin sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned W_DEF   = 5;
    localparam int unsigned OPW_DEF = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins; on a tie the
// requester that was not granted last wins. Output is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (en) begin
            if (&valid) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one external combinational ALU between two requesters, returning
// tagged results. Optional per-requester grant counters: ALU_RR_PERF_CNT_EN.
module alu_rr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [2*W-1:0]   alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_data
`ifdef ALU_RR_PERF_CNT_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    grant;
    logic          last_grant;
    logic          arb_en;
    logic          accept;
    logic          capture;
    logic          retire;
    logic [CW-1:0] lat_cnt;

    // Reset is folded into the enable so no ready is offered while held in reset.
    assign arb_en = (state == IDLE) && reset;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .en         (arb_en),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |(grant & {req1_valid, req0_valid});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= grant[1] ? req1_a  : req0_a;
                alu_b      <= grant[1] ? req1_b  : req0_b;
                alu_op     <= grant[1] ? req1_op : req0_op;
                rsp_id     <= grant[1];
                last_grant <= grant[1];
                lat_cnt    <= CW'(ALU_LAT - 1);
            end else if ((state == EXEC) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - CW'(1);
            end
            if (capture) begin
                rsp_data  <= alu_result;
                rsp_valid <= 1'b1;
            end
            if (retire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_RR_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept && grant[0] && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (accept && grant[1] && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench: one sequencer with ALU_LAT=1 and one with ALU_LAT=3.
module tb_alu_rr_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned W   = 5;
    localparam int unsigned OPW = 4;
    localparam logic [3:0] ALU_MUL = 4'b0010;

    typedef struct packed {
        logic         id;
        logic [2*W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l1, rst_l3;
    logic req0_valid, req1_valid, rsp_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;

    logic req0_ready_l1, req1_ready_l1, rsp_valid_l1, rsp_id_l1;
    logic [W-1:0] alu_a_l1, alu_b_l1;
    logic [OPW-1:0] alu_op_l1;
    logic [2*W-1:0] alu_result_l1, rsp_data_l1;

    logic req0_ready_l3, req1_ready_l3, rsp_valid_l3, rsp_id_l3;
    logic [W-1:0] alu_a_l3, alu_b_l3;
    logic [OPW-1:0] alu_op_l3;
    logic [2*W-1:0] alu_result_l3, rsp_data_l3;

`ifdef ALU_RR_PERF_CNT_EN
    logic [15:0] grant_cnt0_l1, grant_cnt1_l1, grant_cnt0_l3, grant_cnt1_l3;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    int   lg_m     = 1;
    int   cnt0_m   = 0;
    int   cnt1_m   = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        case (op)
            ALU_ADD: return ea + eb;
            ALU_SUB: return ea - eb;
            default: return ea * eb;
        endcase
    endfunction

    assign alu_result_l1 = alu_f(alu_a_l1, alu_b_l1, alu_op_l1);
    assign alu_result_l3 = alu_f(alu_a_l3, alu_b_l3, alu_op_l3);

    alu_rr_sequencer #(.W(W), .OPW(OPW), .ALU_LAT(1)) u_l1 (
        .clock(clk), .reset(rst_l1),
        .req0_valid(req0_valid), .req0_ready(req0_ready_l1),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_l1),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a_l1), .alu_b(alu_b_l1), .alu_op(alu_op_l1),
        .alu_result(alu_result_l1),
        .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_l1), .rsp_data(rsp_data_l1)
`ifdef ALU_RR_PERF_CNT_EN
        , .grant_cnt0(grant_cnt0_l1), .grant_cnt1(grant_cnt1_l1)
`endif
    );

    alu_rr_sequencer #(.W(W), .OPW(OPW), .ALU_LAT(3)) u_l3 (
        .clock(clk), .reset(rst_l3),
        .req0_valid(req0_valid), .req0_ready(req0_ready_l3),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_l3),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a_l3), .alu_b(alu_b_l3), .alu_op(alu_op_l3),
        .alu_result(alu_result_l3),
        .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_l3), .rsp_data(rsp_data_l3)
`ifdef ALU_RR_PERF_CNT_EN
        , .grant_cnt0(grant_cnt0_l3), .grant_cnt1(grant_cnt1_l3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called between a negedge and the next posedge with inputs settled and
    // the LAT=1 instance idle; returns one cycle after the response retires.
    task automatic op_cycle_l1(input int bp);
        int             w;
        logic [W-1:0]   la, lb;
        logic [OPW-1:0] lop;
        exp_t           e;
        #1;
        if (req0_valid && req1_valid) w = (lg_m == 0) ? 1 : 0;
        else if (req0_valid)          w = 0;
        else                          w = 1;
        chk("grant_ready0", 32'(req0_ready_l1), 32'(w == 0));
        chk("grant_ready1", 32'(req1_ready_l1), 32'(w == 1));
        la  = (w == 1) ? req1_a  : req0_a;
        lb  = (w == 1) ? req1_b  : req0_b;
        lop = (w == 1) ? req1_op : req0_op;
        e.id   = (w == 1);
        e.data = alu_f(la, lb, lop);
        q1.push_back(e);
        lg_m = w;
        if (w == 1) cnt1_m++; else cnt0_m++;
        @(posedge clk);
        #1;
        if (w == 1) begin
            req1_a  = 5'($urandom_range(0, 31));
            req1_b  = 5'($urandom_range(0, 31));
            req1_op = 4'($urandom_range(0, 2));
        end else begin
            req0_a  = 5'($urandom_range(0, 31));
            req0_b  = 5'($urandom_range(0, 31));
            req0_op = 4'($urandom_range(0, 2));
        end
        @(negedge clk);
        chk("exec_rsp_valid", 32'(rsp_valid_l1), 32'd0);
        chk("exec_readys", 32'({req1_ready_l1, req0_ready_l1}), 32'd0);
        chk("exec_alu_a", 32'(alu_a_l1), 32'(la));
        chk("exec_alu_b", 32'(alu_b_l1), 32'(lb));
        chk("exec_alu_op", 32'(alu_op_l1), 32'(lop));
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid_l1), 32'd1);
        e = q1.pop_front();
        chk("rsp_id", 32'(rsp_id_l1), 32'(e.id));
        chk("rsp_data", 32'(rsp_data_l1), 32'(e.data));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid_l1), 32'd1);
            chk("bp_id", 32'(rsp_id_l1), 32'(e.id));
            chk("bp_data", 32'(rsp_data_l1), 32'(e.data));
            chk("bp_readys", 32'({req1_ready_l1, req0_ready_l1}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_l1 = 1'b0;  rst_l3 = 1'b0;  rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 5'b00010; req0_b = 5'b00001; req0_op = ALU_ADD;
        req1_valid = 1'b1; req1_a = 5'd7;     req1_b = 5'd3;     req1_op = ALU_MUL;

        repeat (2) @(negedge clk);
        chk("rst_ready0", 32'(req0_ready_l1), 32'd0);
        chk("rst_ready1", 32'(req1_ready_l1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_l1), 32'd0);
        chk("rst_alu_a", 32'(alu_a_l1), 32'd0);
        chk("rst_alu_op", 32'(alu_op_l1), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_l1), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id_l1), 32'd0);
`ifdef ALU_RR_PERF_CNT_EN
        chk("rst_cnt0", 32'(grant_cnt0_l1), 32'd0);
`endif

        // Tie on first grant goes to requester 0; 2+1 returns 3
        rst_l1 = 1'b1;
        op_cycle_l1(0);

        // Continuous contention alternates 1,0,1,0
        repeat (4) op_cycle_l1(0);

        // Response backpressure
        op_cycle_l1(5);

        // Requester 0 alone wins back-to-back; include a full-width product
        req1_valid = 1'b0;
        req0_a = 5'd31; req0_b = 5'd31; req0_op = ALU_MUL;
        op_cycle_l1(0);
        op_cycle_l1(0);

        req0_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_readys", 32'({req1_ready_l1, req0_ready_l1}), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid_l1), 32'd0);
        end

`ifdef ALU_RR_PERF_CNT_EN
        chk("perf_cnt0", 32'(grant_cnt0_l1), 32'(cnt0_m));
        chk("perf_cnt1", 32'(grant_cnt1_l1), 32'(cnt1_m));
`endif

        // Reset during EXEC on the ALU_LAT=3 instance
        rst_l1 = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd4; req0_op = ALU_SUB;
        rst_l3 = 1'b1;
        #1;
        chk("l3_ready0", 32'(req0_ready_l3), 32'd1);
        chk("l3_ready1", 32'(req1_ready_l3), 32'd0);
        @(posedge clk);
        #1 req0_a = 5'd20;
        @(negedge clk);
        chk("l3_exec1_valid", 32'(rsp_valid_l3), 32'd0);
        chk("l3_exec1_alu_a", 32'(alu_a_l3), 32'd9);
        @(negedge clk);
        chk("l3_exec2_valid", 32'(rsp_valid_l3), 32'd0);
        rst_l3 = 1'b0;
        #1;
        chk("l3_rst_alu_a", 32'(alu_a_l3), 32'd0);
        chk("l3_rst_readys", 32'({req1_ready_l3, req0_ready_l3}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("l3_rst_no_rsp", 32'(rsp_valid_l3), 32'd0);
        end
        rst_l3 = 1'b1;
        #1;
        chk("l3_regrant", 32'(req0_ready_l3), 32'd1);
        e.id   = 1'b0;
        e.data = alu_f(req0_a, req0_b, req0_op);
        q3.push_back(e);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("l3_lat_wait", 32'(rsp_valid_l3), 32'd0);
        end
        @(negedge clk);
        chk("l3_rsp_valid", 32'(rsp_valid_l3), 32'd1);
        e = q3.pop_front();
        chk("l3_rsp_id", 32'(rsp_id_l3), 32'(e.id));
        chk("l3_rsp_data", 32'(rsp_data_l3), 32'(e.data));
`ifdef ALU_RR_PERF_CNT_EN
        chk("l3_cnt0", 32'(grant_cnt0_l3), 32'd1);
        chk("l3_cnt1", 32'(grant_cnt1_l3), 32'd0);
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("l3_retired", 32'(rsp_valid_l3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
